// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package mem_arb_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 16;
  localparam int WD_W   = 10;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SERVE_INSTR = 2'd1,
    SERVE_DATA  = 2'd2
  } arb_state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } req_id_t;

  // Read data returned when the watchdog forces completion of a dead cycle.
  localparam logic [DATA_W-1:0] OPEN_BUS_DATA = 16'hFFFF;

  // Request fields presented on the shared bus by whichever master owns it.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wr_en;
    logic [1:0]        bytesel;
  } bus_req_t;

endpackage

// File: rtl/ack_watchdog.sv
// Counts cycles a bus grant has waited for completion and flags expiry.
// Latency: expired is combinational on the cycle the count reaches TIMEOUT-1.
// Backpressure: none; the owner decides what to do with expired.
// Ports: clk, reset_n (async active-low); clear holds the count at zero;
//        enable advances the count and qualifies expired; expired out.
module ack_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  import mem_arb_pkg::*;

  // TIMEOUT = 0 wraps LIMIT to all-ones but expiry is masked off below.
  localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Count is 0 on the first granted cycle, so expiry lands on cycle TIMEOUT.
  assign expired = (TIMEOUT != 0) && enable && (count == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between prefetch and load/store.
// Latency: grant 1 cycle after request on a free bus; ack/data pass through same cycle.
// Backpressure: requesters hold access until ack; losers wait, no preemption.
// Ports: clk, reset_n; instr_m_* prefetch master (read only); data_m_* load/store
//        master; q_m_* shared bus towards memory; timeout pulses on forced ack.
module mem_bus_arbiter #(
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [18:0] instr_m_addr,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  output logic [15:0] instr_m_data_in,
  input  logic [18:0] data_m_addr,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  output logic        data_m_ack,
  output logic [15:0] data_m_data_in,
  output logic [18:0] q_m_addr,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  input  logic        q_m_ack,
  input  logic [15:0] q_m_data_in,
  output logic        timeout
);
  import mem_arb_pkg::*;

  arb_state_t  state;
  req_id_t     last_served;

  bus_req_t    instr_req;
  bus_req_t    data_req;
  bus_req_t    grant_req;
  logic        grant_access;
  logic        serving;
  logic        real_ack;
  logic        forced_ack;
  logic        done;
  logic [15:0] resp_data;
  logic        wd_expired;

  // Prefetch is always a full-word read.
  assign instr_req = '{addr: instr_m_addr, wdata: '0, wr_en: 1'b0, bytesel: 2'b11};
  assign data_req  = '{addr: data_m_addr, wdata: data_m_data_out,
                       wr_en: data_m_wr_en, bytesel: data_m_bytesel};

  always_comb begin
    grant_req    = '0;
    grant_access = 1'b0;
    case (state)
      SERVE_INSTR: begin
        grant_req    = instr_req;
        grant_access = instr_m_access;
      end
      SERVE_DATA: begin
        grant_req    = data_req;
        grant_access = data_m_access;
      end
      default: begin
        grant_req    = '0;
        grant_access = 1'b0;
      end
    endcase
  end

  assign serving = (state != IDLE);

  // A withdrawn request is an abort: any ack or expiry that cycle is dropped.
  // A real ack beats a coincident watchdog expiry.
  assign real_ack   = grant_access & q_m_ack;
  assign forced_ack = grant_access & ~q_m_ack & wd_expired;
  assign done       = real_ack | forced_ack;
  assign resp_data  = forced_ack ? OPEN_BUS_DATA : q_m_data_in;

  assign q_m_addr     = grant_req.addr;
  assign q_m_data_out = grant_req.wdata;
  assign q_m_wr_en    = grant_req.wr_en;
  assign q_m_bytesel  = grant_req.bytesel;
  assign q_m_access   = grant_access;

  assign instr_m_ack     = (state == SERVE_INSTR) & done;
  assign instr_m_data_in = (state == SERVE_INSTR) ? resp_data : '0;
  assign data_m_ack      = (state == SERVE_DATA) & done;
  assign data_m_data_in  = (state == SERVE_DATA) ? resp_data : '0;
  assign timeout         = forced_ack;

  ack_watchdog #(.TIMEOUT(ACK_TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (~serving),
    .enable  (serving & ~q_m_ack),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_served <= INSTR;
    end else begin
      case (state)
        IDLE: begin
          if (instr_m_access && data_m_access) begin
            state <= (last_served == INSTR) ? SERVE_DATA : SERVE_INSTR;
          end else if (data_m_access) begin
            state <= SERVE_DATA;
          end else if (instr_m_access) begin
            state <= SERVE_INSTR;
          end
        end
        SERVE_INSTR, SERVE_DATA: begin
          if (!grant_access) begin
            state <= IDLE;
          end else if (done) begin
            state       <= IDLE;
            last_served <= (state == SERVE_DATA) ? DATA : INSTR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
